// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings and small op-decoding helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Whether operand A is treated as two's complement for this op.
  function automatic logic op_a_signed(input logic [2:0] op);
    return !(op == MDU_MULHU || op == MDU_DIVU || op == MDU_REMU);
  endfunction

  // Whether operand B is treated as two's complement for this op.
  function automatic logic op_b_signed(input logic [2:0] op);
    return !(op == MDU_MULHSU || op == MDU_MULHU || op == MDU_DIVU || op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the MDU.
// Handshake: the master raises start with MDUOp/A/B valid; the request is
// taken on any rising edge where busy=0 (IDLE or DONE). busy stays high
// from the cycle after acceptance until the result is ready, then done
// pulses for one cycle with C valid. There is no back-pressure on done.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  mdu_state_e       state_dbg;

  modport master (output start, MDUOp, A, B, input busy, done, C, state_dbg);
  modport slave  (input start, MDUOp, A, B, output busy, done, C, state_dbg);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, bit_i};
  // When the divisor fits, shifted-div < div < 2^WIDTH, so the low bits suffice.
  assign diff    = shifted[WIDTH-1:0] - div_i;
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/mdu.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Multiply: shift-add on operand magnitudes, sign applied at the end.
// Divide: restoring radix-2 on magnitudes, signs applied at the end.
// Build option MDU_FAST_MUL_EN: multiplies use one combinational product
// and skip the RUN phase; divides are unaffected.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] mag_q, mag_d;     // multiplicand or divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;     // {hi, lo} product or {remainder, quotient}
  logic             neg_q, neg_d;     // product / quotient sign
  logic             rneg_q, rneg_d;   // remainder sign
  logic [WIDTH-1:0] c_q, c_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero, sgn_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, div_next;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, fin_res;

  assign a_neg   = op_a_signed(bus.MDUOp) & bus.A[WIDTH-1];
  assign b_neg   = op_b_signed(bus.MDUOp) & bus.B[WIDTH-1];
  assign a_mag   = a_neg ? -bus.A : bus.A;
  assign b_mag   = b_neg ? -bus.B : bus.B;
  assign b_zero  = (bus.B == '0);
  assign sgn_ovf = bus.MDUOp[2] & ~bus.MDUOp[0] & (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.B);

  // Shift-add: add the multiplicand into the high half when the LSB is set,
  // then shift the whole product right by one.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[W2-1:WIDTH]),
    .bit_i (acc_q[WIDTH-1]),
    .div_i (mag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );
  assign div_next = {step_rem, acc_q[WIDTH-2:0], step_q};

  assign prod_s = neg_q  ? -acc_q             : acc_q;
  assign quo_s  = neg_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
  assign rem_s  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  // Final result selection by operation.
  always_comb begin
    fin_res = prod_s[WIDTH-1:0];
    case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_res = prod_s[W2-1:WIDTH];
      MDU_DIV, MDU_DIVU:               fin_res = quo_s;
      MDU_REM, MDU_REMU:               fin_res = rem_s;
      default:                         fin_res = prod_s[WIDTH-1:0];
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    c_d     = c_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          op_d   = bus.MDUOp;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (bus.MDUOp[2]) begin
            mag_d = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            mag_d = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
          end
          if (bus.MDUOp[2] && b_zero) begin
            c_d     = bus.MDUOp[1] ? bus.A : '1;
            state_d = DONE;
          end else if (sgn_ovf) begin
            c_d     = bus.MDUOp[1] ? '0 : bus.A;
            state_d = DONE;
          end else begin
`ifdef MDU_FAST_MUL_EN
            if (!bus.MDUOp[2]) begin
              acc_d   = W2'(a_mag) * W2'(b_mag);
              state_d = FIN;
            end else begin
              state_d = RUN;
            end
`else
            state_d = RUN;
`endif
          end
        end
      end
      RUN: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        c_d     = fin_res;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      c_q     <= c_d;
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == FIN);
  assign bus.done      = (state_q == DONE);
  assign bus.C         = c_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan cases, reset abort,
// back-to-back issue, ignored mid-run start and a short random sweep.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Independent reference using 64-bit arithmetic.
  function automatic logic [W-1:0] ref_mdu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      MDU_MULH:   begin p = sa * sb; r = p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; r = p[63:32]; end
      MDU_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      MDU_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      MDU_DIVU: r = (b == 0) ? '1 : a / b;
      MDU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      MDU_REMU: r = (b == 0) ? a : a % b;
      default:  begin p = sa * sb; r = p[31:0]; end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return op[2] ? DIV_LAT : MUL_LAT;
  endfunction

  // Issue one op now, then follow it to its done pulse.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_c, input int exp_lat, input bit glitch,
                        input string name);
    int cyc;
    int busy_cnt;
    logic [W-1:0] exp_v;
    bus.start = 1'b1;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(exp_c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.MDUOp = 3'($urandom_range(0, 7));
    cyc = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = glitch && (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: no done pulse within %0d cycles", name, cyc);
      return;
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_lat - 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy cycles %0d (busy at done=%b) expected %0d", name, busy_cnt,
               bus.busy, exp_lat - 1);
    end
    checks++;
    if (bus.C !== exp_v) begin
      errors++;
      $display("FAIL %s C: got %h expected %h", name, bus.C, exp_v);
    end
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.MDUOp = '0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.C !== '0 || bus.state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b C=%h state=%0d expected 0 0 0 IDLE", bus.busy,
               bus.done, bus.C, bus.state_dbg);
    end
    rst = 1'b0;
    idle_gap();
  endtask

  task automatic test_mul();
    idle_gap();
    run_op(MDU_MUL, 32'd7, -32'sd3, 32'hFFFF_FFEB, MUL_LAT, 1'b0, "mul_7x-3");
    idle_gap();
    run_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0, "mulhu_max");
    idle_gap();
    run_op(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b0, "mulh_m1");
    idle_gap();
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0, "mulhsu_m1");
  endtask

  task automatic test_div();
    idle_gap();
    run_op(MDU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b0, "div_-7/2");
    idle_gap();
    run_op(MDU_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 1'b0, "rem_-7/2");
  endtask

  task automatic test_special();
    idle_gap();
    run_op(MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "divu_by0");
    idle_gap();
    run_op(MDU_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0, "remu_by0");
    idle_gap();
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
    idle_gap();
    run_op(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, "rem_ovf");
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    idle_gap();
    bus.start = 1'b1;
    bus.MDUOp = MDU_DIV;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.C !== '0 || bus.state_dbg !== IDLE) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b C=%h state=%0d expected 0 0 0 IDLE", bus.busy,
               bus.done, bus.C, bus.state_dbg);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: activity after reset, got 1 expected 0");
    end
    run_op(MDU_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 1'b0, "mul_after_abort");
  endtask

  task automatic test_back_to_back();
    bit saw_done;
    idle_gap();
    run_op(MDU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0, "b2b_first");
    // Issued in the DONE cycle of the previous op, with a stray start mid-run.
    run_op(MDU_MUL, 32'd6, 32'd6, 32'd36, MUL_LAT, 1'b1, "b2b_mul");
    run_op(MDU_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b0, "b2b_remu");
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL b2b_quiet: extra done pulse, got 1 expected 0");
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = (i == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      idle_gap();
      run_op(op, a, b, ref_mdu(op, a, b), ref_lat(op, a, b), 1'b0, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_reset_abort();
    test_special();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit for the RISC-V M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the EX stage beside the ALU: takes the same A/B operands, and its result feeds the EX result mux in parallel with ALU C.
- The control unit stalls the core while busy=1 and selects C when done=1.

Parameters:
- WIDTH, 32, operand/result width; WIDTH must be even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- MDUOp  in  3  operation code; encodings from the shared include.
- A  in  WIDTH  operand rs1.
- B  in  WIDTH  operand rs2.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; C valid in that cycle.
- C  out  WIDTH  result; holds its value until the next accepted start completes.

Behaviour:
- Reset (synchronous, active-high, clk only): state=IDLE, busy=0, done=0, C=0, counter=0, internal accumulators=0. Reset asserted mid-operation aborts immediately with no done pulse.
- States:
  - IDLE: start=1 latches A, B and MDUOp.
    - If the op is a divide/rem and B=0, or a signed overflow case: go to DONE.
    - Otherwise go to RUN with counter=0.
  - RUN: one iteration per cycle. At counter=WIDTH-1 go to FIN.
  - FIN: final sign correction / high-low select; write C; go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is accepted as if in IDLE (back-to-back ops).
- busy=1 in RUN and FIN.
- start during RUN/FIN is ignored. Operand changes after acceptance have no effect.
- Latency, start at edge 0:
  - Normal op: done high in cycle WIDTH+2 (34 for WIDTH=32).
  - Special case: done high in cycle 1.
- Multiply: shift-add on |A|,|B| magnitudes into a 2*WIDTH product; sign fixed in FIN.
  - MUL returns low half.
  - MULH: signed×signed, high half.
  - MULHSU: signed A × unsigned B, high half.
  - MULHU: unsigned×unsigned, high half.
- Divide: restoring radix-2 on magnitudes. Quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- Special cases (RISC-V defined, no trap):
  - DIV/DIVU by 0 → all ones.
  - REM/REMU by 0 → A.
  - DIV with A=most-negative, B=-1 → A.
  - REM with A=most-negative, B=-1 → 0.
- Undefined MDUOp codes behave as MUL.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - Multiply ops use a single combinational WIDTH×WIDTH product; IDLE→FIN directly, so done is high in cycle 2.
  - Divide behaviour is unchanged.
- Undefined: all ops use the iterative path above.
- Port list and the handshake are identical either way.

Decomposition:
- The shared define include (same file as the ALU op codes) holds:
  - MDU op codes: MDU_MUL=000, MDU_MULH=001, MDU_MULHSU=010, MDU_MULHU=011, MDU_DIV=100, MDU_DIVU=101, MDU_REM=110, MDU_REMU=111.
  - State encodings IDLE/RUN/FIN/DONE.
- One natural sub-module: mdu_div_step, a combinational single restoring-divide iteration (partial remainder, divisor → next remainder, quotient bit).

Test Plan:
- MUL A=7, B=-3 → done in cycle 34, C=0xFFFFFFEB; busy high in cycles 1–33.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → C=0xFFFFFFFE. MULH same operands → C=0x00000000.
- DIV A=-7, B=2 → C=0xFFFFFFFD; REM with same operands → C=0xFFFFFFFF.
- DIVU A=5, B=0 → done in cycle 1, C=0xFFFFFFFF; REM A=0x80000000, B=-1 → C=0.
- Assert rst at cycle 10 of a DIV → next cycle busy=0, done=0, C=0, and no later done pulse. A following MUL 3×4 → C=12.
- Back-to-back: start asserted in DONE with MUL 6×6 → accepted; done 34 cycles later with C=36. A start pulsed during RUN is ignored.
